// File: rtl/sha256_host_ctrl.sv
//----------------------------------------------------------------------------
// sha256_host_ctrl: host initiator for the simplified_sha256 co-processor.
// Writes the message, pulses start, waits for done, streams the 8 hash words.
// Optional macro SHA_HOST_TIMEOUT_EN adds a WAIT_DONE watchdog and timeout_err.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module sha256_host_ctrl #(
  parameter int NUM_OF_WORDS   = 30,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [31:0] seed,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        start,
  input  logic        done,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        host_owns_mem,
  output logic        busy,
  output logic        hash_valid,
  output logic [2:0]  hash_idx,
  output logic [31:0] hash_word,
`ifdef SHA_HOST_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        run_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE_MSG = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_READ_REQ  = 3'd4,
    S_READ_LAST = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [10:0] c_last_word  = 11'(NUM_OF_WORDS - 1);
  localparam logic [10:0] c_last_start = 11'(START_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_cnt;
  logic [31:0] r_word;
  logic [15:0] r_msg_addr;
  logic [15:0] r_out_addr;
  logic        r_rd_pend;
  logic [2:0]  r_rd_idx;
  logic        r_hash_valid;
  logic [2:0]  r_hash_idx;
  logic [31:0] r_hash_word;
  logic        r_run_done;
  logic        w_go_ok;
  logic        w_timeout;

  assign w_go_ok = (r_state == S_IDLE) && go;

`ifdef SHA_HOST_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_timeout_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_WAIT_DONE && w_next == S_WAIT_DONE) ? r_to_cnt + 32'd1 : '0;
      if (w_go_ok)
        r_timeout_err <= 1'b0;
      else if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:      if (go) w_next = S_WRITE_MSG;
      S_WRITE_MSG: if (r_cnt == c_last_word) w_next = S_START;
      S_START:     if (r_cnt == c_last_start) w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (done) begin
          w_next = S_READ_REQ;
`ifdef SHA_HOST_TIMEOUT_EN
        end else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
`endif
        end
      end
      S_READ_REQ:  if (r_cnt[2:0] == 3'd7) w_next = S_READ_LAST;
      S_READ_LAST: w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // r_cnt restarts at zero on every state change, so each phase counts from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_word       <= '0;
      r_msg_addr   <= '0;
      r_out_addr   <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_idx     <= '0;
      r_hash_valid <= 1'b0;
      r_hash_idx   <= '0;
      r_hash_word  <= '0;
      r_run_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 11'd1;
      if (w_go_ok) begin
        r_word     <= seed;
        r_msg_addr <= message_addr;
        r_out_addr <= output_addr;
      end else if (r_state == S_WRITE_MSG) begin
        r_word <= {r_word[30:0], r_word[31]};
      end
      // Read data arrives the cycle after the address; register it one more time.
      r_rd_pend    <= (r_state == S_READ_REQ);
      r_rd_idx     <= r_cnt[2:0];
      r_hash_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_hash_word <= mem_read_data;
        r_hash_idx  <= r_rd_idx;
      end
      r_run_done <= (r_state == S_DONE);
    end
  end

  always_comb begin
    mem_addr = '0;
    case (r_state)
      S_WRITE_MSG: mem_addr = r_msg_addr + 16'(r_cnt);
      S_READ_REQ:  mem_addr = r_out_addr + {13'd0, r_cnt[2:0]};
      default:     mem_addr = '0;
    endcase
  end

  assign mem_we         = (r_state == S_WRITE_MSG);
  assign mem_write_data = (r_state == S_WRITE_MSG) ? r_word : 32'd0;
  assign start          = (r_state == S_START);
  assign host_owns_mem  = (r_state == S_WRITE_MSG) || (r_state == S_READ_REQ) ||
                          (r_state == S_READ_LAST);
  assign busy           = (r_state != S_IDLE);
  assign hash_valid     = r_hash_valid;
  assign hash_idx       = r_hash_idx;
  assign hash_word      = r_hash_word;
  assign run_done       = r_run_done;

endmodule

`default_nettype wire

// File: tb/tb_sha256_host_ctrl.sv
//----------------------------------------------------------------------------
// tb_sha256_host_ctrl: scoreboard bench with shared memory and hasher responder.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_sha256_host_ctrl;

  localparam int N = 30;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic [31:0] seed;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        start;
  logic        done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        host_owns_mem;
  logic        busy;
  logic        hash_valid;
  logic [2:0]  hash_idx;
  logic [31:0] hash_word;
  logic        run_done;
`ifdef SHA_HOST_TIMEOUT_EN
  logic        timeout_err;
`endif

  sha256_host_ctrl #(
    .NUM_OF_WORDS  (N),
    .START_CYCLES  (S),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .seed          (seed),
    .message_addr  (message_addr),
    .output_addr   (output_addr),
    .start         (start),
    .done          (done),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .host_owns_mem (host_owns_mem),
    .busy          (busy),
    .hash_valid    (hash_valid),
    .hash_idx      (hash_idx),
    .hash_word     (hash_word),
`ifdef SHA_HOST_TIMEOUT_EN
    .timeout_err   (timeout_err),
`endif
    .run_done      (run_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory; pl_req models the hasher depositing its 8 result words.
  logic [31:0] mem [0:65535];
  logic        pl_req;
  logic [15:0] pl_base;
  logic [31:0] pl_val;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    if (pl_req)
      for (int i = 0; i < 8; i++) mem[pl_base + 16'(i)] <= pl_val + 32'(i);
    mem_read_data <= mem[mem_addr];
  end

  typedef struct {
    int          kind;  // 0 write, 1 start, 2 hash, 3 run_done
    int          cyc;
    logic [15:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic push(input int k, input int c, input logic [15:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.cyc = c; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop(input int k, input logic [15:0] a, input logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: kind %0d addr/idx %h data %h at cycle %0d, nothing expected",
               k, a, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.a !== a || e.d !== d) begin
        n_bad++;
        $display("FAIL event: got kind %0d cyc %0d a %h d %h, expected kind %0d cyc %0d a %h d %h",
                 k, cyc, a, d, e.kind, e.cyc, e.a, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (mem_we)     pop(0, mem_addr, mem_write_data);
      if (start)      pop(1, 16'd0, 32'd0);
      if (hash_valid) pop(2, {13'd0, hash_idx}, hash_word);
      if (run_done)   pop(3, 16'd0, 32'd0);
    end
  end

  // One complete run. dly: cycles from WAIT_DONE entry-1 to the done pulse
  // (1 = entry cycle); dly < 0 means done is never raised.
  task automatic run(input logic [31:0] sd, input logic [15:0] ma, input logic [15:0] oa,
                     input int dly, input logic [31:0] hb, input bit hold, input bit gw);
    int          gc;
    int          cd;
    int          cend;
    logic [31:0] w;
    @(posedge clk); #1;
    go = 1'b1; seed = sd; message_addr = ma; output_addr = oa;
    pl_base = oa; pl_val = hb;
    gc = cyc;
    cd = gc + N + S + dly;
    w  = sd;
    for (int m = 0; m < N; m++) begin
      push(0, gc + 1 + m, ma + 16'(m), w);
      w = {w[30:0], w[31]};
    end
    for (int k = 0; k < S; k++) push(1, gc + N + 1 + k, 16'd0, 32'd0);
    if (dly >= 0) begin
      for (int i = 0; i < 8; i++) push(2, cd + 3 + i, 16'(i), hb + 32'(i));
      push(3, cd + 11, 16'd0, 32'd0);
      cend = cd + 12;
    end else begin
      cend = gc + N + S + 1 + 52;
    end
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      go     = gw && (cyc == gc + N + S + 2);
      pl_req = (dly >= 0) && (cyc == cd - 1);
      done   = (dly >= 0) && ((cyc == cd) || (hold && cyc >= gc + N + 1 && cyc <= cd));
      if (cyc == gc + 1)     chk("owns_mem_write", 32'(host_owns_mem), 32'd1);
      if (cyc == gc + N + 1) chk("owns_mem_start", 32'(host_owns_mem), 32'd0);
`ifdef SHA_HOST_TIMEOUT_EN
      if (cyc == gc + 1) chk("timeout_err_cleared", 32'(timeout_err), 32'd0);
      if (dly < 0 && cyc == gc + N + S + 1 + 49) chk("timeout_err_early", 32'(timeout_err), 32'd0);
      if (dly < 0 && cyc == gc + N + S + 1 + 50) begin
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
      end
`endif
      if (cyc >= cend) break;
    end
    chk("busy_after_run", 32'(busy), 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int gc;
    logic [31:0] w;
    reset_n = 1'b0; go = 1'b0; done = 1'b0; pl_req = 1'b0;
    seed = '0; message_addr = '0; output_addr = '0; pl_base = '0; pl_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_hash_valid", 32'(hash_valid), 32'd0);
    chk("rst_run_done", 32'(run_done), 32'd0);
    chk("rst_owns_mem", 32'(host_owns_mem), 32'd0);
`ifdef SHA_HOST_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
    reset_n = 1'b1;

    run(32'h01234675, 16'd0, 16'd1000, 500, 32'h000000A0, 1'b0, 1'b0);
    run(32'h80000001, 16'hFFF0, 16'hFFFC, 4, 32'hB0B0_0000, 1'b0, 1'b0);
    run(32'hDEADBEEF, 16'h0100, 16'h0200, 10, 32'hC0000000, 1'b0, 1'b1);
    run(32'h00000001, 16'h0300, 16'h0400, 1, 32'h12340000, 1'b1, 1'b0);

    // Reset while writing word 10, then a clean restart.
    @(posedge clk); #1;
    go = 1'b1; seed = 32'hF0F0F0F0; message_addr = 16'h0500; output_addr = 16'h0600;
    gc = cyc;
    w  = 32'hF0F0F0F0;
    for (int m = 0; m < 10; m++) begin
      push(0, gc + 1 + m, 16'h0500 + 16'(m), w);
      w = {w[30:0], w[31]};
    end
    @(posedge clk); #1;
    go = 1'b0;
    for (int t = 0; t < 50 && cyc < gc + 11; t++) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_owns_mem", 32'(host_owns_mem), 32'd0);
    chk("midrst_queue", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run(32'h0000ABCD, 16'h0700, 16'h0800, 3, 32'h55550000, 1'b0, 1'b0);

`ifdef SHA_HOST_TIMEOUT_EN
    run(32'h11111111, 16'h0900, 16'h0A00, -1, 32'd0, 1'b0, 1'b0);
    run(32'h22222222, 16'h0900, 16'h0A00, 2, 32'h77770000, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
